// File: rtl/breath_pkg.sv
// breath_pkg: shared state encoding and mode constants for the breathing duty sequencer.
package breath_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } breath_state_t;

  localparam logic MODE_TRI = 1'b0;
  localparam logic MODE_SAW = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: free-running 0..DIV counter producing a one-cycle tick at DIV.
// Held at zero while clr is high so every run starts with a full step interval.
module step_prescaler #(
  parameter int unsigned DIV = 2_499_999
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW    = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] DIV_C = CW'(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at DIV, forced to zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == DIV_C)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == DIV_C);

endmodule

// File: rtl/breathing_duty_gen.sv
// breathing_duty_gen: rise / hold / fall / hold duty sequencer feeding pwm_enhanced.
// Optional squared-law output stage enabled by defining BREATH_GAMMA_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | stopped, duty 0, prescaler cleared; en=1 latches mode/step
// RISE    | add step on each tick, clamp at 2**R (sawtooth wraps to 0)
// HOLD_HI | triangle only: park at 2**R for HOLD_STEPS ticks
// FALL    | subtract step on each tick, clamp at 0
// HOLD_LO | park at 0 for HOLD_STEPS ticks, re-latch mode/step on exit
module breathing_duty_gen
  import breath_pkg::*;
#(
  parameter int unsigned R          = 8,
  parameter int unsigned STEP_DIV   = 2_499_999,
  parameter int unsigned HOLD_STEPS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         mode,
  input  logic [R-1:0] step_size,
  output logic [R:0]   duty,
  output logic         step_pulse,
  output logic         peak_pulse,
  output logic         busy
);

  // A hold of zero steps still lasts one tick, so the load value bottoms out at 0.
  localparam int unsigned   HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [R:0]    DUTY_MAX  = {1'b1, {R{1'b0}}};

  breath_state_t state_q, state_d;
  logic [R:0]    lin_q, lin_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          mode_q, mode_d;
  logic [R-1:0]  step_q, step_d;
  logic          step_pulse_q, step_pulse_d;
  logic          peak_pulse_q, peak_pulse_d;

  logic          tick;
  logic          pre_clr;
  logic [R-1:0]  step_in;
  logic [R+1:0]  sum, dif;
  logic [R:0]    rise_val, fall_val;

  // Abort clears the prescaler in the same edge that returns the FSM to IDLE.
  assign pre_clr = (state_q == IDLE) || !en;

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_step_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .tick  (tick)
  );

  assign step_in = (step_size == '0) ? R'(1) : step_size;

  // Saturating step arithmetic, two guard bits so nothing overflows before the clamp.
  always_comb begin
    sum      = {1'b0, lin_q} + {2'b00, step_q};
    dif      = {1'b0, lin_q} - {2'b00, step_q};
    rise_val = (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[R:0];
    fall_val = dif[R+1] ? '0 : dif[R:0];
  end

  // Sequencer next state; abort on en low overrides everything, including a tick.
  always_comb begin
    state_d      = state_q;
    lin_d        = lin_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    step_d       = step_q;
    peak_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        lin_d  = '0;
        hold_d = '0;
        if (en) begin
          state_d = RISE;
          mode_d  = mode;
          step_d  = step_in;
        end
      end
      RISE: begin
        if (tick) begin
          if ((mode_q == MODE_SAW) && (lin_q == DUTY_MAX)) begin
            lin_d  = '0;
            mode_d = mode;
            step_d = step_in;
          end else begin
            lin_d = rise_val;
            if (rise_val == DUTY_MAX) begin
              peak_pulse_d = 1'b1;
              if (mode_q == MODE_TRI) begin
                state_d = HOLD_HI;
                hold_d  = HOLD_LOAD;
              end
            end
          end
        end
      end
      HOLD_HI: begin
        if (tick) begin
          if (hold_q == '0) begin
            state_d = FALL;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      FALL: begin
        if (tick) begin
          lin_d = fall_val;
          if (fall_val == '0) begin
            state_d = HOLD_LO;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      HOLD_LO: begin
        if (tick) begin
          if (hold_q == '0) begin
            state_d = RISE;
            mode_d  = mode;
            step_d  = step_in;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lin_d   = '0;
        hold_d  = '0;
      end
    endcase

    step_pulse_d = (lin_d != lin_q);

    if ((state_q != IDLE) && !en) begin
      state_d      = IDLE;
      lin_d        = '0;
      hold_d       = '0;
      step_pulse_d = 1'b0;
      peak_pulse_d = 1'b0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lin_q        <= '0;
      hold_q       <= '0;
      mode_q       <= MODE_TRI;
      step_q       <= '0;
      step_pulse_q <= 1'b0;
      peak_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lin_q        <= lin_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
      step_pulse_q <= step_pulse_d;
      peak_pulse_q <= peak_pulse_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef BREATH_GAMMA_EN
  logic [R:0] gam_q, gam_d;
  logic       gstep_q, gstep_d;
  logic       gpeak_q, gpeak_d;

  // Square the linear value one cycle behind it; 2**R squares back to 2**R exactly.
  // The drop to zero after an abort is silent, like the linear output.
  always_comb begin
    gam_d   = (R+1)'(({{(R+1){1'b0}}, lin_q} * {{(R+1){1'b0}}, lin_q}) >> R);
    gstep_d = (gam_d != gam_q) && (state_q != IDLE);
    gpeak_d = peak_pulse_q;
  end

  // Gamma pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gam_q   <= '0;
      gstep_q <= 1'b0;
      gpeak_q <= 1'b0;
    end else begin
      gam_q   <= gam_d;
      gstep_q <= gstep_d;
      gpeak_q <= gpeak_d;
    end
  end

  assign duty       = gam_q;
  assign step_pulse = gstep_q;
  assign peak_pulse = gpeak_q;
`else
  assign duty       = lin_q;
  assign step_pulse = step_pulse_q;
  assign peak_pulse = peak_pulse_q;
`endif

endmodule

// File: tb/tb_breathing_duty_gen.sv
// tb_breathing_duty_gen: scoreboard bench for breathing_duty_gen (R=4, STEP_DIV=3,
// HOLD_STEPS=2). Expected duty values follow the squared law when BREATH_GAMMA_EN is set.
`timescale 1ns/1ps
module tb_breathing_duty_gen;

  localparam int R          = 4;
  localparam int STEP_DIV   = 3;
  localparam int HOLD_STEPS = 2;
  localparam int DMAX       = 16;
  localparam int TICK_CYC   = STEP_DIV + 1;
  localparam int HOLD_GAP   = (HOLD_STEPS + 1) * TICK_CYC;
`ifdef BREATH_GAMMA_EN
  localparam int GX = 1;
`else
  localparam int GX = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         mode;
  logic [R-1:0] step_size;
  logic [R:0]   duty;
  logic         step_pulse;
  logic         peak_pulse;
  logic         busy;

  breathing_duty_gen #(
    .R          (R),
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .step_size  (step_size),
    .duty       (duty),
    .step_pulse (step_pulse),
    .peak_pulse (peak_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R:0] duty;
    logic       peak;
    int         gap;
  } ev_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_steps  = 0;
  int         cyc      = 0;
  int         last_pulse_cyc = 0;
  bit         mon_en   = 1'b0;
  bit         have_prev_pulse = 1'b0;
  logic [R:0] prev_duty = '0;
  logic [R:0] last_push = '0;
  int         pend_gap = 0;
  bit         first_push = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [R:0] expd(input int lin);
`ifdef BREATH_GAMMA_EN
    return (R+1)'((lin * lin) >> R);
`else
    return (R+1)'(lin);
`endif
  endfunction

  // Scoreboard monitor: every step_pulse pops one expected event.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      n_checks++;
      if (step_pulse !== (duty !== prev_duty)) begin
        n_fail++;
        $display("FAIL pulse_vs_change: step_pulse=%0b duty %0d->%0d", step_pulse, prev_duty, duty);
      end
      if (step_pulse === 1'b1) begin
        n_steps++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: duty=%0d with no expected event", duty);
        end else begin
          e = sb.pop_front();
          if (duty !== e.duty) begin
            n_fail++;
            $display("FAIL step_duty: got %0d expected %0d", duty, e.duty);
          end
          n_checks++;
          if (peak_pulse !== e.peak) begin
            n_fail++;
            $display("FAIL step_peak: got %0b expected %0b at duty %0d", peak_pulse, e.peak, e.duty);
          end
          if (have_prev_pulse && e.gap != 0) begin
            n_checks++;
            if (cyc - last_pulse_cyc != e.gap) begin
              n_fail++;
              $display("FAIL step_gap: got %0d cycles expected %0d at duty %0d", cyc - last_pulse_cyc, e.gap, e.duty);
            end
          end
        end
        last_pulse_cyc = cyc;
        have_prev_pulse = 1'b1;
      end else begin
        n_checks++;
        if (peak_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL lone_peak: peak_pulse=%0b without step_pulse", peak_pulse);
        end
      end
    end
    prev_duty = duty;
  end

  task automatic sb_reset();
    sb.delete();
    last_push       = '0;
    pend_gap        = 0;
    first_push      = 1'b1;
    n_steps         = 0;
    have_prev_pulse = 1'b0;
  endtask

  // Push the output event for a new linear value; repeats of the output merge gaps.
  task automatic push_lin(input int lin, input bit pk, input int gap);
    ev_t        e;
    logic [R:0] g;
    g = expd(lin);
    if (g == last_push) begin
      pend_gap += gap;
    end else begin
      e.duty = g;
      e.peak = pk;
      e.gap  = first_push ? 0 : pend_gap + gap;
      sb.push_back(e);
      pend_gap   = 0;
      first_push = 1'b0;
      last_push  = g;
    end
  endtask

  task automatic push_triangle(input int s, input int periods);
    int lin;
    int nl;
    int gap;
    lin = 0;
    gap = TICK_CYC;
    for (int p = 0; p < periods; p++) begin
      do begin
        nl = (lin + s > DMAX) ? DMAX : lin + s;
        push_lin(nl, nl == DMAX, gap);
        gap = TICK_CYC;
        lin = nl;
      end while (lin < DMAX);
      gap = HOLD_GAP;
      do begin
        nl = (lin < s) ? 0 : lin - s;
        push_lin(nl, 1'b0, gap);
        gap = TICK_CYC;
        lin = nl;
      end while (lin > 0);
      gap = HOLD_GAP;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    en     = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb_reset();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    en        = 1'b0;
    mode      = 1'b0;
    step_size = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (duty !== '0)       begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %0b expected 0", step_pulse); end
    n_checks++; if (peak_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_peak: got %0b expected 0", peak_pulse); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL idle_hold_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_latency_async_reset();
    int n;
    int k;
    reset     = 1'b0;
    en        = 1'b1;
    mode      = 1'b0;
    step_size = 4'd4;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rise_entry_busy: got %0b expected 1", busy); end
    n = 1;
    while (step_pulse !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n != 5 + GX) begin n_fail++; $display("FAIL first_step_cycle: got %0d expected %0d", n, 5 + GX); end
    n_checks++; if (duty !== expd(4)) begin n_fail++; $display("FAIL first_step_duty: got %0d expected %0d", duty, expd(4)); end
    k = 0;
    while (!(step_pulse === 1'b1 && duty === expd(8)) && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (duty !== expd(8)) begin n_fail++; $display("FAIL reach_8_timeout: got %0d expected %0d", duty, expd(8)); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (duty !== '0)         begin n_fail++; $display("FAIL async_duty: got %0d expected 0", duty); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL async_busy: got %0b expected 0", busy); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL async_step: got %0b expected 0", step_pulse); end
  endtask

  task automatic test_triangle();
    int exp_n;
    do_reset();
    mode      = 1'b0;
    step_size = 4'd4;
    push_triangle(4, 2);
    exp_n  = sb.size();
    mon_en = 1'b1;
    en     = 1'b1;
    drain(600);
    mon_en = 1'b0;
    n_checks++; if (sb.size() != 0)  begin n_fail++; $display("FAIL tri_drain: %0d events left expected 0", sb.size()); end
    n_checks++; if (n_steps != exp_n) begin n_fail++; $display("FAIL tri_step_count: got %0d expected %0d", n_steps, exp_n); end
  endtask

  task automatic test_clamp();
    int exp_n;
    do_reset();
    mode      = 1'b0;
    step_size = 4'd5;
    push_triangle(5, 1);
    exp_n  = sb.size();
    mon_en = 1'b1;
    en     = 1'b1;
    drain(400);
    mon_en = 1'b0;
    n_checks++; if (sb.size() != 0)  begin n_fail++; $display("FAIL clamp_drain: %0d events left expected 0", sb.size()); end
    n_checks++; if (n_steps != exp_n) begin n_fail++; $display("FAIL clamp_step_count: got %0d expected %0d", n_steps, exp_n); end
  endtask

  task automatic test_step_zero();
    int exp_n;
    do_reset();
    mode      = 1'b0;
    step_size = 4'd0;
    push_triangle(1, 1);
    exp_n  = sb.size();
    mon_en = 1'b1;
    en     = 1'b1;
    drain(600);
    mon_en = 1'b0;
    n_checks++; if (sb.size() != 0)  begin n_fail++; $display("FAIL zero_drain: %0d events left expected 0", sb.size()); end
    n_checks++; if (n_steps != exp_n) begin n_fail++; $display("FAIL zero_step_count: got %0d expected %0d", n_steps, exp_n); end
  endtask

  task automatic test_sawtooth();
    int i;
    do_reset();
    mode      = 1'b1;
    step_size = 4'd8;
    push_lin(8, 1'b0, TICK_CYC);
    push_lin(16, 1'b1, TICK_CYC);
    push_lin(0, 1'b0, TICK_CYC);
    push_lin(8, 1'b0, TICK_CYC);
    push_lin(16, 1'b1, TICK_CYC);
    push_lin(0, 1'b0, TICK_CYC);
    push_lin(4, 1'b0, TICK_CYC);
    push_lin(8, 1'b0, TICK_CYC);
    push_lin(12, 1'b0, TICK_CYC);
    push_lin(16, 1'b1, TICK_CYC);
    mon_en = 1'b1;
    en     = 1'b1;
    i = 0;
    while (sb.size() > 6 && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_checks++; if (sb.size() != 6) begin n_fail++; $display("FAIL saw_midramp: %0d events left expected 6", sb.size()); end
    step_size = 4'd4;
    drain(300);
    mon_en = 1'b0;
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL saw_drain: %0d events left expected 0", sb.size()); end
    n_checks++; if (n_steps != 10)  begin n_fail++; $display("FAIL saw_step_count: got %0d expected 10", n_steps); end
  endtask

  task automatic test_abort();
    int seen;
    int i;
    do_reset();
    mode      = 1'b0;
    step_size = 4'd4;
    en        = 1'b1;
    seen = 0;
    i    = 0;
    while (seen < 2 && i < 200) begin
      @(negedge clk);
      if (step_pulse === 1'b1 && duty === expd(8)) seen++;
      i++;
    end
    n_checks++; if (seen != 2) begin n_fail++; $display("FAIL abort_find_fall8: saw %0d expected 2", seen); end
    repeat (3 - GX) @(negedge clk);
    n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL abort_pre_busy: got %0b expected 1", busy); end
    n_checks++; if (duty !== expd(8)) begin n_fail++; $display("FAIL abort_pre_duty: got %0d expected %0d", duty, expd(8)); end
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_step: got %0b expected 0", step_pulse); end
    n_checks++; if (peak_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_peak: got %0b expected 0", peak_pulse); end
    repeat (GX) @(negedge clk);
    n_checks++; if (duty !== '0)         begin n_fail++; $display("FAIL abort_duty: got %0d expected 0", duty); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_step_late: got %0b expected 0", step_pulse); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    mode      = 1'b0;
    step_size = '0;
    test_reset();
    test_latency_async_reset();
    test_triangle();
    test_clamp();
    test_step_zero();
    test_sawtooth();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
